// File: rtl/sparc_ctrl_pkg.sv
// Shared encodings for the SPARC-style control sequencer:
// FSM states, RAM opcodes, ALU operand selects and op-field constants.
package sparc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH_MAR = 4'd0,
      FETCH_RD  = 4'd1,
      FETCH_IR  = 4'd2,
      DECODE    = 4'd3,
      EXEC      = 4'd4,
      LD_MAR    = 4'd5,
      LD_RD     = 4'd6,
      LD_WB     = 4'd7,
      ST_MAR    = 4'd8,
      ST_MDR    = 4'd9,
      ST_WR     = 4'd10,
      TRAP      = 4'd11,
      PC_UPD    = 4'd12
   } state_t;

   localparam logic [1:0] READ_WORD  = 2'b00;
   localparam logic [1:0] WRITE_WORD = 2'b01;

   localparam logic [1:0] SEL_PC = 2'd0;
   localparam logic [1:0] SEL_EA = 2'd1;
   localparam logic [1:0] SEL_RS = 2'd2;

   localparam logic [1:0] OP_MEM    = 2'b11;
   localparam int         STORE_BIT = 21;

   function automatic logic is_wait(input state_t s);
      return (s == FETCH_RD) || (s == LD_RD) || (s == ST_WR);
   endfunction

endpackage

// File: rtl/mfc_timer.sv
// MFC wait-cycle counter; raises expired on the LIMIT-th waiting
// cycle without MFC. Cleared on reset and on every state change.
module mfc_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   input  logic run,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   assign expired = run && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (clr || restart)
         cnt <= '0;
      else if (run && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for a SPARC-style datapath.
// Optional MFC watchdog enabled by defining MFC_TIMEOUT_EN.
module control_sequencer
   import sparc_ctrl_pkg::*;
#(
   parameter int MFC_TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [31:0] IR_Out,
   input  logic        MFC,
   input  logic        trap_req,
   output logic        IR_Enable,
   output logic        MAR_Enable,
   output logic        MDR_Enable,
   output logic        MDR_Mux_S,
   output logic        RAM_enable,
   output logic        PSR_Enable,
   output logic        TBR_Enable,
   output logic        PC_Enable,
   output logic        RF_Enable,
   output logic [1:0]  RAM_OpCode,
   output logic [1:0]  alu_src_sel,
   output logic        mem_fault,
   output logic [3:0]  state_out
);

   state_t state, nxt;
   logic   hold;
   logic   expired;
   logic   mem_op, store;
   logic   unused_ir;

   assign mem_op    = (IR_Out[31:30] == OP_MEM);
   assign store     = IR_Out[STORE_BIT];
   assign unused_ir = ^{IR_Out[29:22], IR_Out[20:0]};
   assign state_out = state;

`ifdef MFC_TIMEOUT_EN
   logic fault;

   mfc_timer #(.LIMIT(MFC_TIMEOUT)) u_timer (
      .clk     (Clk),
      .clr     (Clr),
      .restart (nxt != state),
      .run     (is_wait(state) && !MFC),
      .expired (expired)
   );

   always_ff @(posedge Clk) begin
      if (Clr)
         fault <= 1'b0;
      else if (expired)
         fault <= 1'b1;
   end

   assign mem_fault = fault;
`else
   logic unused_cfg;

   assign expired    = 1'b0;
   assign mem_fault  = 1'b0;
   assign unused_cfg = (MFC_TIMEOUT > 0);
`endif

   // hold marks the quiet first FETCH_MAR cycle after reset
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state <= FETCH_MAR;
         hold  <= 1'b1;
      end else begin
         state <= nxt;
         hold  <= 1'b0;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         FETCH_MAR: nxt = hold ? FETCH_MAR : FETCH_RD;
         FETCH_RD:
            if (MFC)          nxt = FETCH_IR;
            else if (expired) nxt = TRAP;
         FETCH_IR:  nxt = DECODE;
         DECODE:
            if (trap_req)     nxt = TRAP;
            else if (mem_op)  nxt = store ? ST_MAR : LD_MAR;
            else              nxt = EXEC;
         EXEC:      nxt = PC_UPD;
         LD_MAR:    nxt = LD_RD;
         LD_RD:
            if (MFC)          nxt = LD_WB;
            else if (expired) nxt = TRAP;
         LD_WB:     nxt = PC_UPD;
         ST_MAR:    nxt = ST_MDR;
         ST_MDR:    nxt = ST_WR;
         ST_WR:
            if (MFC)          nxt = PC_UPD;
            else if (expired) nxt = TRAP;
         TRAP:      nxt = PC_UPD;
         PC_UPD:    nxt = FETCH_MAR;
         default:   nxt = FETCH_MAR;
      endcase
   end

   always_comb begin
      IR_Enable   = 1'b0;
      MAR_Enable  = 1'b0;
      MDR_Enable  = 1'b0;
      MDR_Mux_S   = 1'b0;
      RAM_enable  = 1'b0;
      PSR_Enable  = 1'b0;
      TBR_Enable  = 1'b0;
      PC_Enable   = 1'b0;
      RF_Enable   = 1'b0;
      RAM_OpCode  = READ_WORD;
      alu_src_sel = SEL_PC;
      if (!hold) begin
         unique case (state)
            FETCH_MAR: MAR_Enable = 1'b1;
            FETCH_RD:  RAM_enable = 1'b1;
            FETCH_IR:  IR_Enable  = 1'b1;
            EXEC: begin
               RF_Enable   = 1'b1;
               alu_src_sel = SEL_RS;
            end
            LD_MAR, ST_MAR: begin
               MAR_Enable  = 1'b1;
               alu_src_sel = SEL_EA;
            end
            // read data is captured into MDR the cycle MFC arrives
            LD_RD: begin
               RAM_enable = 1'b1;
               MDR_Mux_S  = MFC;
               MDR_Enable = MFC;
            end
            LD_WB:     RF_Enable  = 1'b1;
            ST_MDR:    MDR_Enable = 1'b1;
            ST_WR: begin
               RAM_enable = 1'b1;
               RAM_OpCode = WRITE_WORD;
            end
            TRAP: begin
               PSR_Enable = 1'b1;
               TBR_Enable = 1'b1;
            end
            PC_UPD:    PC_Enable  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected state and
// outputs are queued by the stimulus and checked by a negedge monitor.
module tb_control_sequencer;

   localparam logic [3:0] S_FMAR = 4'd0,  S_FRD  = 4'd1,  S_FIR  = 4'd2;
   localparam logic [3:0] S_DEC  = 4'd3,  S_EXEC = 4'd4,  S_LMAR = 4'd5;
   localparam logic [3:0] S_LRD  = 4'd6,  S_LWB  = 4'd7,  S_SMAR = 4'd8;
   localparam logic [3:0] S_SMDR = 4'd9,  S_SWR  = 4'd10, S_TRAP = 4'd11;
   localparam logic [3:0] S_PCU  = 4'd12;

   // {IR,MAR,MDR,MUX,RAM,PSR,TBR,PC,RF}
   localparam logic [8:0] E_NONE = 9'b000000000;
   localparam logic [8:0] E_IR   = 9'b100000000;
   localparam logic [8:0] E_MAR  = 9'b010000000;
   localparam logic [8:0] E_MDR  = 9'b001000000;
   localparam logic [8:0] E_MUX  = 9'b000100000;
   localparam logic [8:0] E_RAM  = 9'b000010000;
   localparam logic [8:0] E_PSR  = 9'b000001000;
   localparam logic [8:0] E_TBR  = 9'b000000100;
   localparam logic [8:0] E_PC   = 9'b000000010;
   localparam logic [8:0] E_RF   = 9'b000000001;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01;
   localparam logic [1:0] PC = 2'd0, EA = 2'd1, RS = 2'd2;

   localparam logic [31:0] IR_ALU = 32'h8000_0000;
   localparam logic [31:0] IR_LD  = 32'hC000_0000;
   localparam logic [31:0] IR_ST  = 32'hC020_0000;

   typedef struct {
      int         tag;
      logic [3:0] st;
      logic [8:0] en;
      logic [1:0] op;
      logic [1:0] sel;
      logic       flt;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic [31:0] IR_Out = '0;
   logic        MFC = 1'b0;
   logic        trap_req = 1'b0;
   logic        IR_Enable, MAR_Enable, MDR_Enable, MDR_Mux_S, RAM_enable;
   logic        PSR_Enable, TBR_Enable, PC_Enable, RF_Enable;
   logic [1:0]  RAM_OpCode, alu_src_sel;
   logic        mem_fault;
   logic [3:0]  state_out;

   exp_t q[$];
   int   vectors = 0;
   int   fails = 0;
   int   issued = 0;

   control_sequencer #(.MFC_TIMEOUT(16)) dut (
      .Clk         (Clk),
      .Clr         (Clr),
      .IR_Out      (IR_Out),
      .MFC         (MFC),
      .trap_req    (trap_req),
      .IR_Enable   (IR_Enable),
      .MAR_Enable  (MAR_Enable),
      .MDR_Enable  (MDR_Enable),
      .MDR_Mux_S   (MDR_Mux_S),
      .RAM_enable  (RAM_enable),
      .PSR_Enable  (PSR_Enable),
      .TBR_Enable  (TBR_Enable),
      .PC_Enable   (PC_Enable),
      .RF_Enable   (RF_Enable),
      .RAM_OpCode  (RAM_OpCode),
      .alu_src_sel (alu_src_sel),
      .mem_fault   (mem_fault),
      .state_out   (state_out)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [17:0] got, want;
         e = q.pop_front();
         got = {state_out, IR_Enable, MAR_Enable, MDR_Enable, MDR_Mux_S,
                RAM_enable, PSR_Enable, TBR_Enable, PC_Enable, RF_Enable,
                RAM_OpCode, alu_src_sel, mem_fault};
         want = {e.st, e.en, e.op, e.sel, e.flt};
         vectors++;
         if (got !== want) begin
            fails++;
            $display("FAIL cyc%0d st/en/op/sel/flt got=%b want=%b",
                     e.tag, got, want);
         end
      end
   end

   task automatic step(input logic c, input logic m, input logic t,
                       input logic [31:0] ir, input logic [3:0] st,
                       input logic [8:0] en, input logic [1:0] op,
                       input logic [1:0] sel, input logic flt);
      exp_t e;
      @(posedge Clk);
      #1;
      Clr = c; MFC = m; trap_req = t; IR_Out = ir;
      e.tag = issued; e.st = st; e.en = en;
      e.op = op; e.sel = sel; e.flt = flt;
      q.push_back(e);
      issued++;
   endtask

   initial begin
      @(posedge Clk);
      #1;
      Clr = 1'b1;
      // ALU instruction after reset, MFC one cycle late
      step(0, 0, 0, IR_ALU, S_FMAR, E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_ALU, S_FMAR, E_MAR,  RD, PC, 0);
      step(0, 0, 0, IR_ALU, S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 1, 0, IR_ALU, S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 0, IR_ALU, S_FIR,  E_IR,   RD, PC, 0);
      step(0, 0, 0, IR_ALU, S_DEC,  E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_ALU, S_EXEC, E_RF,   RD, RS, 0);
      step(0, 0, 0, IR_ALU, S_PCU,  E_PC,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FMAR, E_MAR,  RD, PC, 0);
      // load
      step(0, 1, 0, IR_LD,  S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FIR,  E_IR,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_DEC,  E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_LMAR, E_MAR,  RD, EA, 0);
      step(0, 0, 0, IR_LD,  S_LRD,  E_RAM,  RD, PC, 0);
      step(0, 1, 0, IR_LD,  S_LRD,  E_RAM | E_MDR | E_MUX, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_LWB,  E_RF,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_PCU,  E_PC,   RD, PC, 0);
      step(0, 0, 0, IR_ST,  S_FMAR, E_MAR,  RD, PC, 0);
      // store, write held for three cycles
      step(0, 1, 0, IR_ST,  S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 0, IR_ST,  S_FIR,  E_IR,   RD, PC, 0);
      step(0, 0, 0, IR_ST,  S_DEC,  E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_ST,  S_SMAR, E_MAR,  RD, EA, 0);
      step(0, 0, 0, IR_ST,  S_SMDR, E_MDR,  RD, PC, 0);
      step(0, 0, 0, IR_ST,  S_SWR,  E_RAM,  WR, PC, 0);
      step(0, 0, 0, IR_ST,  S_SWR,  E_RAM,  WR, PC, 0);
      step(0, 1, 0, IR_ST,  S_SWR,  E_RAM,  WR, PC, 0);
      step(0, 0, 0, IR_ST,  S_PCU,  E_PC,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FMAR, E_MAR,  RD, PC, 0);
      // trap raised during fetch is only taken in DECODE
      step(0, 1, 1, IR_LD,  S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 1, IR_LD,  S_FIR,  E_IR,   RD, PC, 0);
      step(0, 0, 1, IR_LD,  S_DEC,  E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_TRAP, E_PSR | E_TBR, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_PCU,  E_PC,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FMAR, E_MAR,  RD, PC, 0);
      // reset in the middle of a load read
      step(0, 1, 0, IR_LD,  S_FRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FIR,  E_IR,   RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_DEC,  E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_LMAR, E_MAR,  RD, EA, 0);
      step(1, 0, 0, IR_LD,  S_LRD,  E_RAM,  RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FMAR, E_NONE, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_FMAR, E_MAR,  RD, PC, 0);
`ifdef MFC_TIMEOUT_EN
      for (int i = 0; i < 16; i++)
         step(0, 0, 0, IR_LD, S_FRD, E_RAM, RD, PC, 0);
      step(0, 0, 0, IR_LD,  S_TRAP, E_PSR | E_TBR, RD, PC, 1);
      step(0, 0, 0, IR_LD,  S_PCU,  E_PC,   RD, PC, 1);
      step(1, 0, 0, IR_LD,  S_FMAR, E_MAR,  RD, PC, 1);
      step(0, 0, 0, IR_LD,  S_FMAR, E_NONE, RD, PC, 0);
`else
      for (int i = 0; i < 20; i++)
         step(0, 0, 0, IR_LD, S_FRD, E_RAM, RD, PC, 0);
`endif
      repeat (3) @(posedge Clk);
      if (q.size() != 0) begin
         vectors++;
         fails++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
